// File: rtl/seg7_pair_decoder.sv
// seg7_pair_decoder
// Receive-side monitor for a two-digit 7-segment display. It recovers the hex
// nibbles from the segment drive vectors, commits a pattern only after it has
// held for STABLE_CYCLES cycles, pulses o_Valid on each commit, flags illegal
// glyphs and counts commits.
// Build option: define SEG7_DECODE_SYNC_EN to pass both segment inputs through
// a 2-flop synchroniser (adds 2 cycles of latency) for asynchronous sources.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | after reset, nothing committed yet
// S_SETTLE | counting consecutive unchanged cycles of the input
// S_HOLD   | committed value equals the current input

module seg7_pair_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [6:0] i_Segment1,
  input  logic [6:0] i_Segment2,
  output logic       o_Valid,
  output logic [3:0] o_Digit1,
  output logic [3:0] o_Digit2,
  output logic       o_Error1,
  output logic       o_Error2,
  output logic [7:0] o_Change_Count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

  // Returns {error, nibble}; unknown patterns (all-off included) give nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h7E:   res = {1'b0, 4'h0};
      7'h30:   res = {1'b0, 4'h1};
      7'h6D:   res = {1'b0, 4'h2};
      7'h79:   res = {1'b0, 4'h3};
      7'h33:   res = {1'b0, 4'h4};
      7'h5B:   res = {1'b0, 4'h5};
      7'h5F:   res = {1'b0, 4'h6};
      7'h70:   res = {1'b0, 4'h7};
      7'h7F:   res = {1'b0, 4'h8};
      7'h7B:   res = {1'b0, 4'h9};
      7'h77:   res = {1'b0, 4'hA};
      7'h1F:   res = {1'b0, 4'hB};
      7'h4E:   res = {1'b0, 4'hC};
      7'h3D:   res = {1'b0, 4'hD};
      7'h4F:   res = {1'b0, 4'hE};
      7'h47:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  logic [6:0]  seg1_raw;
  logic [6:0]  seg2_raw;
  logic [13:0] vec_now;
  logic [13:0] prev_vec_q;
  logic        vec_changed;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        commit;
  logic [4:0]  dec1;
  logic [4:0]  dec2;
  state_t      state_q;
  state_t      state_d;

`ifdef SEG7_DECODE_SYNC_EN
  // Synchroniser flops reset to the "all segments off" level of the pin.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] seg1_meta;
  logic [6:0] seg1_sync;
  logic [6:0] seg2_meta;
  logic [6:0] seg2_sync;

  // Two-stage synchroniser on both segment buses.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      seg1_meta <= SEG_OFF;
      seg1_sync <= SEG_OFF;
      seg2_meta <= SEG_OFF;
      seg2_sync <= SEG_OFF;
    end else begin
      seg1_meta <= i_Segment1;
      seg1_sync <= seg1_meta;
      seg2_meta <= i_Segment2;
      seg2_sync <= seg2_meta;
    end
  end

  assign seg1_raw = seg1_sync;
  assign seg2_raw = seg2_sync;
`else
  assign seg1_raw = i_Segment1;
  assign seg2_raw = i_Segment2;
`endif

  assign vec_now     = ACTIVE_LOW ? {~seg1_raw, ~seg2_raw} : {seg1_raw, seg2_raw};
  assign vec_changed = (vec_now != prev_vec_q);
  assign dec1        = decode_glyph(vec_now[13:7]);
  assign dec2        = decode_glyph(vec_now[6:0]);

  // State register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stability counter and commit decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_SETTLE;
        cnt_d   = 8'd0;
      end
      S_SETTLE: begin
        if (vec_changed) begin
          cnt_d = 8'd0;
        end else if (cnt_q == STABLE_TC) begin
          commit  = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (vec_changed) begin
          state_d = S_SETTLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Stability counter and previous-vector history for change detection.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q      <= 8'd0;
      prev_vec_q <= 14'd0;
    end else begin
      cnt_q      <= cnt_d;
      prev_vec_q <= vec_now;
    end
  end

  // Registered outputs; digits, flags and count move only on a commit.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Valid        <= 1'b0;
      o_Digit1       <= 4'h0;
      o_Digit2       <= 4'h0;
      o_Error1       <= 1'b1;
      o_Error2       <= 1'b1;
      o_Change_Count <= 8'd0;
    end else begin
      o_Valid <= commit;
      if (commit) begin
        o_Digit1       <= dec1[3:0];
        o_Error1       <= dec1[4];
        o_Digit2       <= dec2[3:0];
        o_Error2       <= dec2[4];
        o_Change_Count <= o_Change_Count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed bench for seg7_pair_decoder (STABLE_CYCLES=4, ACTIVE_LOW=1).
module tb_seg7_pair_decoder;

  logic       tb_clk;
  logic       i_Reset;
  logic [6:0] i_Segment1;
  logic [6:0] i_Segment2;
  logic       o_Valid;
  logic [3:0] o_Digit1;
  logic [3:0] o_Digit2;
  logic       o_Error1;
  logic       o_Error2;
  logic [7:0] o_Change_Count;

  int         vectors;
  int         miscompares;
  logic [7:0] exp_count;
  logic       valid_prev;
  logic       b2b_seen;

  localparam int LAT = 6;

  seg7_pair_decoder #(
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .i_Clk          (tb_clk),
    .i_Reset        (i_Reset),
    .i_Segment1     (i_Segment1),
    .i_Segment2     (i_Segment2),
    .o_Valid        (o_Valid),
    .o_Digit1       (o_Digit1),
    .o_Digit2       (o_Digit2),
    .o_Error1       (o_Error1),
    .o_Error2       (o_Error2),
    .o_Change_Count (o_Change_Count)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Watch for o_Valid high on two consecutive cycles.
  initial begin
    valid_prev = 1'b0;
    b2b_seen   = 1'b0;
  end
  always @(negedge tb_clk) begin
    if (o_Valid === 1'b1 && valid_prev === 1'b1) b2b_seen = 1'b1;
    valid_prev = o_Valid;
  end

  // Drive active-high glyphs onto the active-low pins.
  task automatic set_segs(input logic [6:0] g1, input logic [6:0] g2);
    i_Segment1 = ~g1;
    i_Segment2 = ~g2;
  endtask

  // Returns the number of rising edges until o_Valid is seen, -1 on timeout.
  task automatic wait_valid(output int edges);
    bit done;
    edges = -1;
    done  = 1'b0;
    for (int i = 1; i <= 300 && !done; i++) begin
      @(posedge tb_clk);
      #1;
      if (o_Valid === 1'b1) begin
        edges = i;
        done  = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b0;
    set_segs(7'h00, 7'h00);
    #2;
    i_Reset = 1'b1;
    #1;
    vectors++;
    if ({o_Valid, o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count} !== {1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_async: got v=%b d1=%h d2=%h e1=%b e2=%b cnt=%0d, expected v=0 d1=0 d2=0 e1=1 e2=1 cnt=0",
               o_Valid, o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count);
    end
    repeat (3) @(posedge tb_clk);
    #1;
    vectors++;
    if ({o_Valid, o_Error1, o_Error2, o_Change_Count} !== {1'b0, 1'b1, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_held: got v=%b e1=%b e2=%b cnt=%0d, expected v=0 e1=1 e2=1 cnt=0",
               o_Valid, o_Error1, o_Error2, o_Change_Count);
    end
    i_Reset   = 1'b0;
    exp_count = 8'd0;
  endtask

  task automatic test_first_commit();
    int edges;
    set_segs(7'h7E, 7'h30);
    wait_valid(edges);
    exp_count = exp_count + 8'd1;
    vectors++;
    if (edges !== LAT) begin
      miscompares++;
      $display("FAIL first_latency: got %0d edges, expected %0d", edges, LAT);
    end
    vectors++;
    if ({o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count} !== {4'h0, 4'h1, 1'b0, 1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL first_values: got d1=%h d2=%h e1=%b e2=%b cnt=%0d, expected d1=0 d2=1 e1=0 e2=0 cnt=%0d",
               o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count, exp_count);
    end
    @(posedge tb_clk);
    #1;
    vectors++;
    if (o_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL first_strobe_width: got o_Valid=%b one cycle after commit, expected 0", o_Valid);
    end
  endtask

  task automatic test_change_digit1();
    int edges;
    set_segs(7'h79, 7'h30);
    wait_valid(edges);
    exp_count = exp_count + 8'd1;
    vectors++;
    if (edges !== LAT) begin
      miscompares++;
      $display("FAIL change_latency: got %0d edges, expected %0d", edges, LAT);
    end
    vectors++;
    if ({o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count} !== {4'h3, 4'h1, 1'b0, 1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL change_values: got d1=%h d2=%h e1=%b e2=%b cnt=%0d, expected d1=3 d2=1 e1=0 e2=0 cnt=%0d",
               o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count, exp_count);
    end
  endtask

  task automatic test_glitch();
    int edges;
    int early;
    early = 0;
    set_segs(7'h79, 7'h7F);
    repeat (3) begin
      @(posedge tb_clk);
      #1;
      if (o_Valid === 1'b1) early++;
    end
    vectors++;
    if (early !== 0) begin
      miscompares++;
      $display("FAIL glitch_no_commit: got %0d strobes during glitch, expected 0", early);
    end
    set_segs(7'h79, 7'h30);
    wait_valid(edges);
    exp_count = exp_count + 8'd1;
    vectors++;
    if (edges !== LAT) begin
      miscompares++;
      $display("FAIL glitch_latency: got %0d edges after restore, expected %0d", edges, LAT);
    end
    vectors++;
    if ({o_Digit1, o_Digit2, o_Change_Count} !== {4'h3, 4'h1, exp_count}) begin
      miscompares++;
      $display("FAIL glitch_values: got d1=%h d2=%h cnt=%0d, expected d1=3 d2=1 cnt=%0d",
               o_Digit1, o_Digit2, o_Change_Count, exp_count);
    end
  endtask

  task automatic test_illegal();
    int edges;
    set_segs(7'h00, 7'h30);
    wait_valid(edges);
    exp_count = exp_count + 8'd1;
    vectors++;
    if ({edges == LAT, o_Digit1, o_Error1, o_Digit2, o_Error2, o_Change_Count} !== {1'b1, 4'h0, 1'b1, 4'h1, 1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL illegal_off: got edges=%0d d1=%h e1=%b d2=%h e2=%b cnt=%0d, expected edges=%0d d1=0 e1=1 d2=1 e2=0 cnt=%0d",
               edges, o_Digit1, o_Error1, o_Digit2, o_Error2, o_Change_Count, LAT, exp_count);
    end
    set_segs(7'h47, 7'h30);
    wait_valid(edges);
    exp_count = exp_count + 8'd1;
    vectors++;
    if ({edges == LAT, o_Digit1, o_Error1, o_Digit2, o_Error2, o_Change_Count} !== {1'b1, 4'hF, 1'b0, 4'h1, 1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL legal_F: got edges=%0d d1=%h e1=%b d2=%h e2=%b cnt=%0d, expected edges=%0d d1=f e1=0 d2=1 e2=0 cnt=%0d",
               edges, o_Digit1, o_Error1, o_Digit2, o_Error2, o_Change_Count, LAT, exp_count);
    end
  endtask

  task automatic test_wrap();
    int         edges;
    logic [7:0] start_count;
    logic [6:0] g;
    logic [3:0] nib;
    start_count = exp_count;
    for (int i = 0; i < 256; i++) begin
      g   = (i % 2 == 0) ? 7'h7E : 7'h30;
      nib = (i % 2 == 0) ? 4'h0 : 4'h1;
      set_segs(g, g);
      wait_valid(edges);
      exp_count = exp_count + 8'd1;
      vectors++;
      if ({edges == LAT, o_Digit1, o_Digit2, o_Change_Count} !== {1'b1, nib, nib, exp_count}) begin
        miscompares++;
        $display("FAIL wrap_step%0d: got edges=%0d d1=%h d2=%h cnt=%0d, expected edges=%0d d1=%h d2=%h cnt=%0d",
                 i, edges, o_Digit1, o_Digit2, o_Change_Count, LAT, nib, nib, exp_count);
      end
    end
    vectors++;
    if (o_Change_Count !== start_count) begin
      miscompares++;
      $display("FAIL wrap_return: got cnt=%0d after 256 commits, expected %0d", o_Change_Count, start_count);
    end
  endtask

  task automatic test_back_to_back();
    vectors++;
    if (b2b_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: got o_Valid high on consecutive cycles, expected never");
    end
  endtask

  task automatic test_reset_mid_settle();
    int edges;
    set_segs(7'h6D, 7'h79);
    repeat (2) @(posedge tb_clk);
    #3;
    i_Reset = 1'b1;
    #1;
    vectors++;
    if ({o_Valid, o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count} !== {1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL midreset_async: got v=%b d1=%h d2=%h e1=%b e2=%b cnt=%0d, expected v=0 d1=0 d2=0 e1=1 e2=1 cnt=0",
               o_Valid, o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count);
    end
    repeat (2) @(posedge tb_clk);
    #1;
    i_Reset   = 1'b0;
    exp_count = 8'd0;
    wait_valid(edges);
    exp_count = exp_count + 8'd1;
    vectors++;
    if (edges !== LAT) begin
      miscompares++;
      $display("FAIL midreset_latency: got %0d edges after release, expected %0d", edges, LAT);
    end
    vectors++;
    if ({o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count} !== {4'h2, 4'h3, 1'b0, 1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL midreset_values: got d1=%h d2=%h e1=%b e2=%b cnt=%0d, expected d1=2 d2=3 e1=0 e2=0 cnt=%0d",
               o_Digit1, o_Digit2, o_Error1, o_Error2, o_Change_Count, exp_count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_count   = 8'd0;
    i_Reset     = 1'b0;
    i_Segment1  = 7'h7F;
    i_Segment2  = 7'h7F;
    test_reset();
    test_first_commit();
    test_change_digit1();
    test_glitch();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_mid_settle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_pair_decoder.md
# seg7_pair_decoder

Reads back a pair of 7-segment drive vectors, as produced for the two-digit display on the ice40 board, and recovers the hex digits they show. Each pattern change must hold for a programmable number of cycles before it is committed. The block then pulses a valid strobe with both decoded nibbles, flags illegal patterns and counts committed changes. It is the receive-side counterpart of the segment encoder. It serves as an on-chip display monitor and as a self-checking scoreboard in benches.

## Interface
- STABLE_CYCLES, 4: consecutive unchanged cycles required before commit; legal range 1–255.
- ACTIVE_LOW, 1: 1 = segment inputs are active-low (board wiring); 0 = active-high.
- i_Clk  in  1  system clock (12 MHz on board).
- i_Reset  in  1  reset. Asynchronous assert, active-high; all state returns to reset values immediately.
- i_Segment1  in  7  digit 1 segments, bit 6 = A … bit 0 = G.
- i_Segment2  in  7  digit 2 segments, same ordering.
- o_Valid  out  1  one-cycle strobe on each commit.
- o_Digit1  out  4  decoded nibble, digit 1; held between commits.
- o_Digit2  out  4  decoded nibble, digit 2; held between commits.
- o_Error1  out  1  committed digit-1 pattern is not a legal glyph; held.
- o_Error2  out  1  same for digit 2.
- o_Change_Count  out  8  number of commits since reset, wraps 255→0.

## Operation
- Inputs are normalised to active-high (inverted when ACTIVE_LOW=1) and concatenated into a 14-bit vector {seg1, seg2}.
- Legal glyphs (active-high A..G):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Any other pattern, including all-off, decodes to nibble 0 with the matching error flag set.
- FSM states:
  - S_IDLE (after reset, nothing committed yet)
  - S_SETTLE (counting stability)
  - S_HOLD (committed value equals current input)
- S_IDLE → S_SETTLE on the first cycle after reset; the stability counter starts at 0.
- S_SETTLE:
  - The counter clears on any change of the 14-bit vector. Otherwise it increments, saturating at STABLE_CYCLES.
  - When it reaches STABLE_CYCLES, commit: update digits and error flags, pulse o_Valid, increment o_Change_Count. Go to S_HOLD.
- S_HOLD:
  - On any change of the vector, go to S_SETTLE with the counter at 0.
  - If the vector returns to the committed value before stabilising, it still commits again (o_Valid pulses, count increments).
- The first stable value after reset always commits, whatever its value.
- A single glitch shorter than STABLE_CYCLES never commits. It only restarts settling.
- o_Change_Count wraps modulo 256 with no flag.

## Timing
- Reset values:
  - o_Valid=0, o_Digit1=0, o_Digit2=0, o_Error1=1, o_Error2=1, o_Change_Count=0
  - FSM = S_IDLE
- Latency: o_Valid is high in the cycle after exactly STABLE_CYCLES+1 rising edges following the edge where a new value is first present. This holds only if the value is unchanged throughout.
- o_Digit*/o_Error* update on the same edge that raises o_Valid. o_Change_Count shows the new value in that same cycle.
- o_Valid is never high on two consecutive cycles.
- Asserting reset mid-settle discards the pending value. After release, timing restarts from S_IDLE.
- All outputs are registered; no combinational path from input to output.

## Configuration
- SEG7_DECODE_SYNC_EN:
  - Defined: both segment inputs pass through a 2-flop synchroniser (reset to the inactive level) before normalisation. Latency increases by 2 cycles. Use this for pins driven from an external or asynchronous source.
  - Undefined: inputs are used directly, for same-clock sources. Latency is as stated above.

## Test plan
- Reset, ACTIVE_LOW=1, STABLE_CYCLES=4, drive seg1=~7E, seg2=~30 → single o_Valid 6 edges after first presentation; Digit1=0, Digit2=1, errors 0, count=1.
- Change seg1 to ~79 and hold → one o_Valid; Digit1=3, Digit2 unchanged at 1, count=2.
- Glitch seg2 to ~7F for 3 cycles, then back to ~30 → no commit until it holds again; then one o_Valid with Digit2=1, count=3.
- Drive seg1=~00 (all off) → o_Error1=1, Digit1=0 on commit; drive ~47 → Digit1=F, o_Error1=0.
- Force 256 distinct alternating commits → o_Change_Count returns to same value (wrap); o_Valid never two cycles back-to-back.
- Assert i_Reset 2 cycles into settling → outputs at reset values asynchronously; first stable value after release commits, count=1.
